// File: rtl/branch_counter_table_if.sv
// branch_counter_table_if: lookup/update bus of the branch counter table.
interface branch_counter_table_if #(
  parameter int CTR_BITS = 2,
  parameter int HW       = 4
);
  logic                pred_valid;
  logic [31:0]         pred_pc;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic [HW-1:0]       upd_hist;
  logic                upd_taken;
  logic                upd_reinit;
  logic                pred_out_valid;
  logic                pred_taken;
  logic [CTR_BITS-1:0] pred_ctr;
  logic [HW-1:0]       pred_hist;
  modport master (
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_hist, upd_taken, upd_reinit,
    input  pred_out_valid, pred_taken, pred_ctr, pred_hist
  );
  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_hist, upd_taken, upd_reinit,
    output pred_out_valid, pred_taken, pred_ctr, pred_hist
  );
endinterface

// File: rtl/branch_counter_table.sv
// branch_counter_table: saturating-counter direction predictor, gshare or bimodal indexing.
module branch_counter_table #(
  parameter int CTR_BITS  = 2,
  parameter int DEPTH     = 64,
  parameter int HIST_BITS = 4,
  parameter int INIT_VAL  = 0
) (
  input logic i_clk,
  input logic i_rst_n,
  branch_counter_table_if.slave bus
);
  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int HW       = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [IDX_BITS-1:0] HMASK = IDX_BITS'((1 << HIST_BITS) - 1);
  localparam logic [CTR_BITS-1:0] CMAX  = '1;
  localparam logic [CTR_BITS-1:0] HALF  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] INIT  = CTR_BITS'(INIT_VAL);
  logic [CTR_BITS-1:0] r_tab [DEPTH];
  logic [HW-1:0]       r_ghr;
  logic [HW-1:0]       r_hist;
  logic [CTR_BITS-1:0] r_ctr;
  logic                r_vld;
  logic [IDX_BITS-1:0] w_pidx;
  logic [IDX_BITS-1:0] w_uidx;
  logic [CTR_BITS-1:0] w_cur;
  logic [CTR_BITS-1:0] w_nxt;
  logic [HW-1:0]       w_ghr_nxt;
  logic                w_unused;
  // HMASK is zero in bimodal mode, so the history term drops out of the index
  assign w_pidx    = bus.pred_pc[IDX_BITS+1:2] ^ (IDX_BITS'(r_ghr) & HMASK);
  assign w_uidx    = bus.upd_pc[IDX_BITS+1:2] ^ (IDX_BITS'(bus.upd_hist) & HMASK);
  assign w_cur     = r_tab[w_uidx];
  assign w_ghr_nxt = (HIST_BITS == 0) ? '0 : HW'({r_ghr, bus.upd_taken});
  assign w_unused  = ^{bus.pred_pc, bus.upd_pc};
  always_comb
    w_nxt = bus.upd_reinit ? (bus.upd_taken ? HALF : HALF - 1'b1)
          : bus.upd_taken  ? ((w_cur == CMAX) ? w_cur : w_cur + 1'b1)
          :                  ((w_cur == '0)   ? w_cur : w_cur - 1'b1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_tab[k] <= INIT;
      r_ghr  <= '0;
    end else if (bus.upd_valid) begin
      r_tab[w_uidx] <= w_nxt;
      r_ghr         <= w_ghr_nxt;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_ctr  <= '0;
      r_hist <= '0;
    end else begin
      r_vld <= bus.pred_valid;
      if (bus.pred_valid) begin
        r_ctr  <= r_tab[w_pidx];
        r_hist <= r_ghr;
      end
    end
  assign bus.pred_out_valid = r_vld;
  assign bus.pred_taken     = r_ctr[CTR_BITS-1];
  assign bus.pred_ctr       = r_ctr;
  assign bus.pred_hist      = r_hist;
endmodule

// File: doc/branch_counter_table.md
BRANCH_COUNTER_TABLE -- requirements
Module: branch_counter_table

Interface
REQ-001 Parameter CTR_BITS, default 2: width of each saturating counter, legal range 2..4.
REQ-002 Parameter DEPTH, default 64: number of counters, a power of two, legal range 4..1024; IDX_BITS = log2(DEPTH).
REQ-003 Parameter HIST_BITS, default 4: global history length, legal range 0..IDX_BITS; 0 selects bimodal indexing; HW = max(HIST_BITS,1).
REQ-004 Parameter INIT_VAL, default 0: counter value loaded on reset, legal range 0..2^CTR_BITS-1.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 pred_valid  in  1  prediction lookup request this cycle.
REQ-008 pred_pc  in  32  PC of the branch being predicted.
REQ-009 upd_valid  in  1  resolved-branch update this cycle.
REQ-010 upd_pc  in  32  PC of the resolved branch.
REQ-011 upd_hist  in  HW  history snapshot returned with this branch's prediction.
REQ-012 upd_taken  in  1  resolved direction, 1 = taken.
REQ-013 upd_reinit  in  1  with upd_valid: reinitialise the entry instead of stepping it.
REQ-014 pred_out_valid  out  1  registered; pred_valid delayed by one cycle.
REQ-015 pred_taken  out  1  registered; MSB of the looked-up counter.
REQ-016 pred_ctr  out  CTR_BITS  registered; full looked-up counter value.
REQ-017 pred_hist  out  HW  registered; GHR value used to form the lookup index.

Function
REQ-018 Storage: DEPTH unsigned CTR_BITS counters plus a HIST_BITS global history register (GHR); HIST_BITS=0 means no GHR, and pred_hist reads 0.
REQ-019 Index = pc[IDX_BITS+1:2] XOR {zeros, history[HIST_BITS-1:0]}, with history in the low bits; lookups use the GHR and updates use upd_hist.
REQ-020 Lookup: when pred_valid is 1 at edge t, the outputs at t+1 reflect the table and GHR contents before any update applied at edge t; no bypass.
REQ-021 When pred_valid is 0 at an edge, pred_out_valid goes to 0 and pred_taken, pred_ctr and pred_hist hold their previous values.
REQ-022 Step on upd_valid=1 and upd_reinit=0: if taken, the counter increments and saturates at 2^CTR_BITS-1; if not taken, it decrements and saturates at 0.
REQ-023 Reinit on upd_valid=1 and upd_reinit=1: the entry loads 2^(CTR_BITS-1) if upd_taken is 1, else 2^(CTR_BITS-1)-1, regardless of its current value.
REQ-024 GHR: on every upd_valid, the GHR shifts left by one, upd_taken enters bit 0 and the MSB is discarded; this also happens on reinit.
REQ-025 With upd_valid=0, no counter and no GHR bit changes.
REQ-026 A lookup and an update in the same cycle, to the same or different entries, are both honoured; the lookup returns the old value (REQ-020).
REQ-027 Only the single indexed entry changes per update; all other entries hold.

Reset
REQ-028 reset=0 immediately, without waiting for a clock edge, sets every counter to INIT_VAL, the GHR to 0, pred_out_valid to 0, pred_taken to 0, pred_ctr to 0 and pred_hist to 0.
REQ-029 While reset=0, all inputs are ignored.
REQ-030 At the first rising clock edge after reset returns to 1, the block operates normally.
REQ-031 Reset asserted mid-operation discards any lookup in flight; pred_out_valid drops to 0 asynchronously.

Verification
REQ-032 Defaults, no history (HIST_BITS=0): 4 taken updates to pc 0x40 -> counter goes 1,2,3,3 and a lookup of 0x40 gives pred_taken=1, pred_ctr=3.
REQ-033 Counter at 3, then 5 not-taken updates -> counter goes 2,1,0,0,0; lookup gives pred_taken=0, pred_ctr=0.
REQ-034 Counter at 3, then update with upd_reinit=1 and upd_taken=0 -> counter=1; repeat with upd_taken=1 -> counter=2.
REQ-035 HIST_BITS=4: 3 taken updates -> GHR=0x7; lookup of pc 0x40 indexes entry 0x10^0x7=0x17 and returns pred_hist=0x7.
REQ-036 Same-cycle lookup and taken update of the same entry holding 1 -> pred_ctr=1 at t+1; a lookup at t+1 returns 2.
REQ-037 Assert reset between two clock edges while pred_out_valid=1 -> all outputs 0 before the next edge, and all counters read INIT_VAL afterwards.
